// File: rtl/dram_read_prefetcher_if.sv
// Bundle of the prefetcher's control, DRAM read-port and core-side signals.
//   start/base_adr/total_blocks : transfer request from the host
//   d_busy/d_dout/d_douten      : DRAM controller read-return path
//   d_req/d_initadr/d_blocks    : DRAM controller read-request path
//   dot/dot_en/deq              : core-side FIFO head and pop handshake
//   busy/done/error             : transfer status
// slave modport is the prefetcher; master modport is its environment.
interface dram_read_prefetcher_if #(
  parameter int unsigned DRAMW = 512
);
  logic             start;
  logic [31:0]      base_adr;
  logic [31:0]      total_blocks;
  logic             d_busy;
  logic [DRAMW-1:0] d_dout;
  logic             d_douten;
  logic [1:0]       d_req;
  logic [31:0]      d_initadr;
  logic [31:0]      d_blocks;
  logic [DRAMW-1:0] dot;
  logic             dot_en;
  logic             deq;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, base_adr, total_blocks, d_busy, d_dout, d_douten, deq,
    input  d_req, d_initadr, d_blocks, dot, dot_en, busy, done, error
  );

  modport slave (
    input  start, base_adr, total_blocks, d_busy, d_dout, d_douten, deq,
    output d_req, d_initadr, d_blocks, dot, dot_en, busy, done, error
  );
endinterface

// File: rtl/dram_read_prefetcher.sv
// Streams total_blocks DRAM blocks starting at base_adr into the sorting core.
// Read bursts are issued only when FIFO space for the whole burst is reserved, because the
// controller return path cannot be stalled. Returned blocks go through a first-word
// fall-through FIFO to the core (dot/dot_en/deq).
// Ports:
//   i_clk    : clock
//   i_rst_n  : asynchronous reset, active low
//   io_bus   : dram_read_prefetcher_if.slave (control, DRAM read port, core port, status)
module dram_read_prefetcher #(
  parameter int unsigned DRAMW     = 512,
  parameter int unsigned BURST     = 8,
  parameter int unsigned DEPTH_LOG = 5,
  parameter int unsigned ADR_STEP  = 8,
  parameter logic [31:0] LAST_ADR  = 32'h07FF_FFF8
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  dram_read_prefetcher_if.slave io_bus
);

  localparam int unsigned DEPTH         = 1 << DEPTH_LOG;
  localparam int unsigned CW            = DEPTH_LOG + 1;
  localparam logic [1:0]  DRAM_REQ_READ = 2'b01;
  localparam logic [32:0] WRAP_SPAN     = 33'(LAST_ADR) + 33'(ADR_STEP);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StRecv, StDrain} state_e;

  state_e              r_state, w_state_nxt;
  logic [31:0]         r_adr, r_req_left, r_del_left;
  logic [CW-1:0]       r_outstanding, r_fifo_count;
  logic [DEPTH_LOG-1:0] r_wptr, r_rptr;
  logic [DRAMW-1:0]    r_mem [DEPTH];
  logic [1:0]          r_d_req;
  logic [31:0]         r_d_initadr, r_d_blocks;
  logic                r_done, r_error;

  logic                w_start, w_issue, w_done_set, w_accept;
  logic                w_beat_ok, w_push, w_pop, w_full, w_err_set, w_room;
  logic [31:0]         w_len, w_adr_nxt;
  logic [32:0]         w_adr_sum;
  logic [CW-1:0]       w_out_nxt;

  assign w_len     = (r_req_left < 32'(BURST)) ? r_req_left : 32'(BURST);
  // Room must cover both blocks already buffered and blocks still in flight.
  assign w_room    = (33'(r_fifo_count) + 33'(r_outstanding) + 33'(w_len)) <= 33'(DEPTH);
  assign w_adr_sum = 33'(r_adr) + 33'(w_len) * 33'(ADR_STEP);
  assign w_adr_nxt = (w_adr_sum > 33'(LAST_ADR)) ? 32'(w_adr_sum - WRAP_SPAN) : w_adr_sum[31:0];

  assign w_full    = (r_fifo_count == CW'(DEPTH));
  assign w_pop     = io_bus.deq && (r_fifo_count != '0);
  assign w_beat_ok = w_accept && (r_outstanding != '0);
  assign w_push    = w_beat_ok && !w_full;
  // Beat with no credit or into a full FIFO is dropped and flagged.
  assign w_err_set = w_accept && !w_push;
  assign w_out_nxt = r_outstanding - CW'(w_beat_ok);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:     if (w_start) w_state_nxt = (io_bus.total_blocks == '0) ? StDrain : StIssue;
      StIssue:    if (w_issue) w_state_nxt = StWaitBusy;
      StWaitBusy: if (io_bus.d_busy) w_state_nxt = StRecv;
      StRecv:     if (w_out_nxt == '0) w_state_nxt = (r_req_left != '0) ? StIssue : StDrain;
      StDrain:    if (w_done_set) w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  // State-decoded control
  always_comb begin
    w_start    = 1'b0;
    w_issue    = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      StIdle:  w_start    = io_bus.start;
      StIssue: w_issue    = !io_bus.d_busy && w_room;
      StDrain: w_done_set = (r_del_left == '0);
      default: ;
    endcase
    // Beats seen while idle are a stale stream from before reset: discard silently.
    w_accept = io_bus.d_douten && (r_state != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_adr         <= '0;
      r_req_left    <= '0;
      r_del_left    <= '0;
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_d_req       <= '0;
      r_d_initadr   <= '0;
      r_d_blocks    <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_d_req     <= w_issue ? DRAM_REQ_READ : 2'b00;
      r_d_initadr <= w_issue ? r_adr : '0;
      r_d_blocks  <= w_issue ? w_len : '0;

      if (w_start) begin
        r_adr      <= io_bus.base_adr;
        r_req_left <= io_bus.total_blocks;
      end else if (w_issue) begin
        r_adr      <= w_adr_nxt;
        r_req_left <= r_req_left - w_len;
      end

      if (w_start)                          r_del_left <= io_bus.total_blocks;
      else if (w_pop && r_del_left != '0)   r_del_left <= r_del_left - 32'd1;

      r_outstanding <= w_out_nxt + (w_issue ? CW'(w_len) : '0);

      if (w_push)                r_wptr <= r_wptr + DEPTH_LOG'(1);
      if (w_pop)                 r_rptr <= r_rptr + DEPTH_LOG'(1);
      if (w_push && !w_pop)      r_fifo_count <= r_fifo_count + CW'(1);
      else if (!w_push && w_pop) r_fifo_count <= r_fifo_count - CW'(1);

      if (w_start)         r_done <= 1'b0;
      else if (w_done_set) r_done <= 1'b1;

      if (w_err_set) r_error <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= io_bus.d_dout;
  end

  assign io_bus.d_req     = r_d_req;
  assign io_bus.d_initadr = r_d_initadr;
  assign io_bus.d_blocks  = r_d_blocks;
  assign io_bus.dot_en    = (r_fifo_count != '0);
  // Gate the unreset storage so dot reads 0 while the FIFO is empty.
  assign io_bus.dot       = (r_fifo_count != '0) ? r_mem[r_rptr] : '0;
  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.done      = r_done;
  assign io_bus.error     = r_error;

endmodule

// File: tb/tb_dram_read_prefetcher.sv
// Self-checking bench for dram_read_prefetcher: a DRAM controller model, a table of directed
// transfers, hand-written sequences for back-pressure, START-while-busy and mid-transfer reset,
// and randomized transfers checked against request/data lists derived from the address rules.
module tb_dram_read_prefetcher;
  localparam int unsigned    DRAMW = 512;
  localparam logic [31:0]    LAST  = 32'h07FF_FFF8;
  localparam logic [1:0]     READ  = 2'b01;
  localparam longint unsigned SPAN = 64'(LAST) + 64'd8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_read_prefetcher_if #(.DRAMW(DRAMW)) bus ();

  dram_read_prefetcher #(
    .DRAMW(DRAMW), .BURST(8), .DEPTH_LOG(5), .ADR_STEP(8), .LAST_ADR(LAST)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] e_radr[$];
  logic [31:0] e_rlen[$];
  logic [31:0] e_dadr[$];
  int          n_req, n_pop;
  logic [31:0] last_radr, last_rlen;
  bit          gap_en = 1'b0;

  // DRAM model state
  logic [31:0] q_adr[$];
  logic [31:0] q_len[$];
  int          m_left = 0;
  int          m_lat = 0;
  logic [31:0] m_adr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] a);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = (a ^ 32'hC3C3_0000) + 32'(i) * 32'h0101_0101;
    return r;
  endfunction

  function automatic logic [31:0] wrap_adr(input longint unsigned a);
    return 32'(a % SPAN);
  endfunction

  // Expected bursts: chunks of up to 8 blocks; block i lives at base + 8*i modulo the span.
  task automatic expect_setup(input logic [31:0] base, input logic [31:0] total);
    e_radr.delete();
    e_rlen.delete();
    e_dadr.delete();
    n_req = 0;
    n_pop = 0;
    last_radr = '0;
    last_rlen = '0;
    for (longint unsigned k = 0; k < 64'(total); k += 8) begin
      e_radr.push_back(wrap_adr(64'(base) + k * 8));
      e_rlen.push_back((64'(total) - k >= 8) ? 32'd8 : 32'(64'(total) - k));
    end
    for (longint unsigned i = 0; i < 64'(total); i++) e_dadr.push_back(wrap_adr(64'(base) + i * 8));
  endtask

  // DRAM controller: queues requests, raises busy, returns len beats with optional gaps.
  initial begin
    bus.d_busy   = 1'b0;
    bus.d_douten = 1'b0;
    bus.d_dout   = '0;
    forever begin
      @(negedge clk);
      if (bus.d_req == READ) begin
        q_adr.push_back(bus.d_initadr);
        q_len.push_back(bus.d_blocks);
      end
      bus.d_douten = 1'b0;
      if (m_left > 0) begin
        bus.d_busy = 1'b1;
        if (m_lat > 0) m_lat--;
        else if (gap_en && $urandom_range(0, 3) == 0) m_lat = 0;
        else begin
          bus.d_douten = 1'b1;
          bus.d_dout   = pat(m_adr);
          m_adr        = wrap_adr(64'(m_adr) + 8);
          m_left--;
        end
      end else if (q_adr.size() != 0) begin
        m_adr      = q_adr.pop_front();
        m_left     = int'(q_len.pop_front());
        m_lat      = gap_en ? int'($urandom_range(0, 2)) : 0;
        bus.d_busy = 1'b1;
      end else begin
        bus.d_busy = 1'b0;
      end
    end
  end

  // One cycle: drive deq, check any request and any popped block against expectations.
  task automatic step(input bit deq_v);
    @(negedge clk);
    bus.deq = deq_v;
    if (bus.d_req != 2'b00) begin
      chk("req_code", 32'(bus.d_req), 32'(READ));
      if (e_radr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_req actual adr=%0h len=%0d required no request", bus.d_initadr,
                 bus.d_blocks);
      end else begin
        chk("req_adr", bus.d_initadr, e_radr.pop_front());
        chk("req_len", bus.d_blocks, e_rlen.pop_front());
      end
      last_radr = bus.d_initadr;
      last_rlen = bus.d_blocks;
      n_req++;
    end
    if (deq_v && bus.dot_en) begin
      if (e_dadr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_dot actual=%0h required no data", bus.dot[31:0]);
      end else begin
        chk_wide("dot", bus.dot, pat(e_dadr.pop_front()));
      end
      n_pop++;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [31:0] total);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.base_adr     = base;
    bus.total_blocks = total;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 0: deq always high, mode 1: random deq
  task automatic finish_run(input int mode, input int budget, input string name, output int cyc);
    cyc = 0;
    do begin
      step(mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      cyc++;
    end while (!bus.done && cyc < budget);
    chk({name, "_done"}, 32'(bus.done), 32'd1);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_error"}, 32'(bus.error), 32'd0);
    chk({name, "_dot_en"}, 32'(bus.dot_en), 32'd0);
    chk({name, "_data_left"}, 32'(e_dadr.size()), 32'd0);
    chk({name, "_reqs_left"}, 32'(e_radr.size()), 32'd0);
  endtask

  task automatic run_case(input logic [31:0] base, input logic [31:0] total, input int mode,
                          input int budget, input string name, output int cyc);
    expect_setup(base, total);
    pulse_start(base, total);
    finish_run(mode, budget, name, cyc);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] total;
    int          nreq;
    logic [31:0] lradr;
    logic [31:0] lrlen;
    bit          gaps;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cyc;
    int k;
    logic [31:0] rb, rt;

    bus.start = 1'b0;
    bus.base_adr = '0;
    bus.total_blocks = '0;
    bus.deq = 1'b0;

    tbl[0] = '{32'h0000_0100, 32'd16, 2, 32'h0000_0140, 32'd8, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'd13, 2, 32'h0000_0040, 32'd5, 1'b0};
    tbl[2] = '{32'h07FF_FFC0, 32'd16, 2, 32'h0000_0000, 32'd8, 1'b0};
    tbl[3] = '{32'h0000_2000, 32'd1,  1, 32'h0000_2000, 32'd1, 1'b1};
    tbl[4] = '{32'h0000_1000, 32'd0,  0, 32'h0000_0000, 32'd0, 1'b0};
    tbl[5] = '{32'h07FF_FFF8, 32'd3,  1, 32'h07FF_FFF8, 32'd3, 1'b0};
    tbl[6] = '{32'h0000_0040, 32'd40, 5, 32'h0000_0140, 32'd8, 1'b1};

    // Reset state
    #13;
    chk("rst_d_req", 32'(bus.d_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_dot_en", 32'(bus.dot_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      gap_en = tbl[i].gaps;
      run_case(tbl[i].base, tbl[i].total, 0, 400, $sformatf("tbl%0d", i), cyc);
      chk($sformatf("tbl%0d_nreq", i), 32'(n_req), 32'(tbl[i].nreq));
      if (tbl[i].nreq > 0) begin
        chk($sformatf("tbl%0d_last_adr", i), last_radr, tbl[i].lradr);
        chk($sformatf("tbl%0d_last_len", i), last_rlen, tbl[i].lrlen);
      end else begin
        chk($sformatf("tbl%0d_zero_latency_ok", i), 32'(cyc <= 2), 32'd1);
      end
    end
    gap_en = 1'b0;

    // Back-pressure: with no pops only 4 bursts fit; 8 pops release the 5th within 2 cycles.
    expect_setup(32'h0000_8000, 32'd64);
    pulse_start(32'h0000_8000, 32'd64);
    repeat (150) step(1'b0);
    chk("bp_nreq_full", 32'(n_req), 32'd4);
    chk("bp_dot_en", 32'(bus.dot_en), 32'd1);
    chk("bp_busy", 32'(bus.busy), 32'd1);
    repeat (8) step(1'b1);
    k = 0;
    do begin
      step(1'b0);
      k++;
    end while (n_req < 5 && k < 10);
    chk("bp_5th_req_seen", 32'(n_req), 32'd5);
    chk("bp_5th_req_latency_ok", 32'(k <= 2), 32'd1);
    finish_run(0, 400, "bp", cyc);

    // START while busy must not disturb the running transfer.
    expect_setup(32'h0000_3000, 32'd24);
    pulse_start(32'h0000_3000, 32'd24);
    repeat (5) step(1'b0);
    bus.start = 1'b1;
    bus.base_adr = 32'h0999_9000;
    bus.total_blocks = 32'd5;
    step(1'b0);
    bus.start = 1'b0;
    finish_run(0, 400, "busy_start", cyc);
    chk("busy_start_pops", 32'(n_pop), 32'd24);

    // Reset in the middle of a burst; the controller keeps streaming stale beats.
    expect_setup(32'h0000_0500, 32'd32);
    pulse_start(32'h0000_0500, 32'd32);
    k = 0;
    while (n_pop < 3 && k < 100) begin
      step(1'b1);
      k++;
    end
    chk("midrst_reached_recv", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_error", 32'(bus.error), 32'd0);
    chk("midrst_dot_en", 32'(bus.dot_en), 32'd0);
    chk("midrst_d_req", 32'(bus.d_req), 32'd0);
    chk_wide("midrst_dot", bus.dot, '0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_setup(32'h0, 32'd0);
    k = 0;
    do begin
      step(1'b0);
      k++;
    end while ((bus.d_busy || m_left > 0) && k < 50);
    chk("stale_beats_error", 32'(bus.error), 32'd0);
    chk("stale_beats_dot_en", 32'(bus.dot_en), 32'd0);
    run_case(32'h0000_0800, 32'd20, 0, 400, "after_rst", cyc);
    chk("after_rst_pops", 32'(n_pop), 32'd20);

    // Randomized transfers
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 2) == 0) rb = LAST - 32'(8 * $urandom_range(0, 40));
      else                           rb = $urandom & 32'h07FF_FFF8;
      rt     = 32'($urandom_range(0, 60));
      gap_en = 1'($urandom_range(0, 1));
      run_case(rb, rt, int'($urandom_range(0, 1)), int'(rt) * 12 + 100,
               $sformatf("rnd%0d", r), cyc);
      chk($sformatf("rnd%0d_pops", r), 32'(n_pop), rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
